// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit: PC, one-cycle memory port, 2-entry decode buffer, redirects
// Optional IFETCH_BOUND_EN: stop issuing at PC_LIMIT and raise o_fetch_done once drained.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(256)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [INST_W-1:0] i_mem_inst,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_fetch_done
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic [INST_W-1:0] r_fifo_inst [2];
  logic [ADDR_W-1:0] r_fifo_pc   [2];

  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_stop;
  logic              w_issue;
  logic              w_wr_idx;
  logic [1:0]        w_count_next;

  assign o_mem_addr   = r_pc;
  assign o_inst_valid = (r_count != 2'd0);
  assign o_inst       = r_fifo_inst[0];
  assign o_inst_pc    = r_fifo_pc[0];

  assign w_pop = o_inst_valid & i_inst_ready;

  // Occupancy after this cycle's pop; a new request is only safe if the
  // returning word is guaranteed a slot.
  assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

`ifdef IFETCH_BOUND_EN
  assign w_stop       = (r_pc == PC_LIMIT);
  assign o_fetch_done = w_stop & (r_count == 2'd0) & ~r_inflight;
`else
  logic w_unused_limit;
  assign w_unused_limit = ^PC_LIMIT;
  assign w_stop         = 1'b0;
  assign o_fetch_done   = 1'b0;
`endif

  assign w_issue      = ~i_branch_taken & ~w_stop & (w_occ < 3'd2);
  assign w_wr_idx     = ((r_count - {1'b0, w_pop}) != 2'd0);
  assign w_count_next = r_count + {1'b0, r_inflight} - {1'b0, w_pop};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_inst[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (i_branch_taken) begin
      // Buffered and returning words belong to the abandoned path.
      r_pc       <= i_branch_target;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(1);
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight <= 1'b0;
      end
      if (w_pop) begin
        r_fifo_inst[0] <= r_fifo_inst[1];
        r_fifo_pc[0]   <= r_fifo_pc[1];
      end
      // Written after the shift so a same-edge push into slot 0 wins.
      if (r_inflight) begin
        r_fifo_inst[w_wr_idx] <= i_mem_inst;
        r_fifo_pc[w_wr_idx]   <= r_inflight_pc;
      end
      r_count <= w_count_next;
    end
  end

endmodule
